// File: rtl/matrix_result_streamer_if.sv
// matrix_result_streamer_if
//   Valid/ready stream carrying the result matrix C out of the MAC
//   read-out block towards the host bridge / UART packer.
//
//   Signals:
//     m_valid     word on m_data is valid
//     m_ready     consumer accepts the word
//     m_data      stream word (DATA_W bits)
//     m_row_last  beat is the last element of a matrix row
//     m_last      beat is the final beat of the run
//
//   Modports:
//     master  the streamer (drives valid/data/flags, samples ready)
//     slave   the consumer
interface matrix_result_streamer_if #(
  parameter int DATA_W = 32
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_row_last;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_row_last,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_row_last,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/matrix_result_streamer.sv
// matrix_result_streamer
//   Read-out end of the 3x3 matrix MAC datapath. After the MAC finishes,
//   a start pulse makes this block read the N*N result words of C
//   (row-major, index i*N+j) through a synchronous-read memory port and
//   stream them out one at a time, marking row and matrix boundaries.
//
//   Parameters:
//     N       matrix dimension (N*N words per run)
//     DATA_W  element / stream word width
//     ADDR_W  read address width, 2^ADDR_W >= N*N
//
//   Ports:
//     clk      rising-edge clock
//     reset    asynchronous active-high reset
//     start    begin a run (only looked at while idle)
//     busy     high whenever a run is in progress
//     done     one-cycle pulse after the final beat has been accepted
//     rd_en    memory read strobe
//     rd_addr  memory read address
//     rd_data  memory read data, valid the cycle after rd_en
//     m_if     stream master (valid/ready, data, row/matrix last flags)
//
//   Optional feature (macro MATRIX_STREAM_CHECKSUM_EN):
//     appends one extra beat carrying the modulo-2^DATA_W sum of all
//     elements; m_last then marks that checksum beat instead of the last
//     data beat.
module matrix_result_streamer #(
  parameter int N      = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  matrix_result_streamer_if.master m_if
);

  localparam int ELEMS = N * N;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

`ifdef MATRIX_STREAM_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    CSUM,
    DONE_STATE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    DONE_STATE
  } state_t;
`endif

  state_t state;
  state_t state_next;

  logic [IDX_W-1:0]  idx;
  logic [COL_W-1:0]  col;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              row_last_q;
  logic              last_q;
  logic              handshake;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  // Outputs are all registered (or decoded from state), so m_ready never
  // reaches an output combinationally.
  assign m_if.m_valid    = valid_q;
  assign m_if.m_data     = data_q;
  assign m_if.m_row_last = row_last_q;
  assign m_if.m_last     = last_q;

  assign handshake = valid_q & m_if.m_ready;
  assign busy      = (state != IDLE);
  assign rd_en     = (state == ISSUE);
  // Address is only meaningful during the strobe; parked at 0 otherwise.
  assign rd_addr   = (state == ISSUE) ? ADDR_W'(idx) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = ISSUE;
      ISSUE:      state_next = CAPTURE;
      CAPTURE:    state_next = SEND;
      SEND: begin
        if (handshake) begin
          if (idx != LAST_IDX) begin
            state_next = ISSUE;
          end else begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE_STATE;
`endif
          end
        end
      end
`ifdef MATRIX_STREAM_CHECKSUM_EN
      CSUM:       if (handshake) state_next = DONE_STATE;
`endif
      DONE_STATE: state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Counters and the stream output register. The read issued in ISSUE
  // returns during CAPTURE, which is where the word is latched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      col        <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      row_last_q <= 1'b0;
      last_q     <= 1'b0;
      done       <= 1'b0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx <= '0;
            col <= '0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
            sum <= '0;
`endif
          end
        end
        CAPTURE: begin
          data_q     <= rd_data;
          valid_q    <= 1'b1;
          row_last_q <= (col == LAST_COL);
`ifdef MATRIX_STREAM_CHECKSUM_EN
          last_q     <= 1'b0;
`else
          last_q     <= (idx == LAST_IDX);
`endif
        end
        SEND: begin
          if (handshake) begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
            sum <= sum + data_q;
`endif
            if (idx != LAST_IDX) begin
              idx     <= idx + 1'b1;
              col     <= (col == LAST_COL) ? '0 : col + 1'b1;
              valid_q <= 1'b0;
            end else begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
              // Checksum beat follows straight on without dropping valid.
              data_q     <= sum + data_q;
              last_q     <= 1'b1;
              row_last_q <= 1'b0;
`else
              // Drop valid now so the accepted last beat is not re-offered.
              valid_q    <= 1'b0;
`endif
            end
          end
        end
`ifdef MATRIX_STREAM_CHECKSUM_EN
        CSUM: begin
          if (handshake) valid_q <= 1'b0;
        end
`endif
        DONE_STATE: begin
          valid_q <= 1'b0;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// tb_matrix_result_streamer
//   Directed bench for matrix_result_streamer: a synchronous-read memory
//   model holds C, a monitor records accepted beats, read addresses and
//   done pulses, and one linear initial block runs each scenario and
//   checks the recordings against hand-computed values.
module tb_matrix_result_streamer;

  localparam int N      = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  localparam int N_BEATS  = 10;
  localparam int DONE_REL = 29;
`else
  localparam int N_BEATS  = 9;
  localparam int DONE_REL = 28;
`endif

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  matrix_result_streamer_if #(.DATA_W(DATA_W)) m_if ();

  matrix_result_streamer #(
    .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .m_if    (m_if)
  );

  int exp_c [9] = '{14, 6, 12, 47, 15, 30, 73, 17, 20};
  logic [DATA_W-1:0] mem [16];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int run_base    = 0;
  bit toggle_ready = 1'b0;

  logic [DATA_W-1:0] beat_data [$];
  bit                beat_rl   [$];
  bit                beat_last [$];
  int                beat_edge [$];
  int                addr_q    [$];
  int                done_cnt;
  int                done_rel;
  int                first_valid_rel;
  int                stab_err;
  int                stall_cnt;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  bit                prev_rl;
  bit                prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous-read memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Consumer ready: tied high, or toggled every cycle for backpressure.
  initial begin
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_if.m_ready = toggle_ready ? ~m_if.m_ready : 1'b1;
    end
  end

  // Monitor sampling at the falling edge; a beat with valid&ready here is
  // accepted at the following rising edge (edge number cyc+1-run_base-1).
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        if (!(m_if.m_valid === 1'b1 && m_if.m_data === prev_data &&
              m_if.m_row_last === prev_rl && m_if.m_last === prev_last))
          stab_err++;
      end
      prev_stall = m_if.m_valid && !m_if.m_ready;
      if (prev_stall) stall_cnt++;
      prev_data = m_if.m_data;
      prev_rl   = m_if.m_row_last;
      prev_last = m_if.m_last;
      if (m_if.m_valid && first_valid_rel < 0) first_valid_rel = cyc - run_base - 1;
      if (m_if.m_valid && m_if.m_ready) begin
        beat_data.push_back(m_if.m_data);
        beat_rl.push_back(m_if.m_row_last);
        beat_last.push_back(m_if.m_last);
        beat_edge.push_back(cyc - run_base);
      end
      if (rd_en) addr_q.push_back(int'(rd_addr));
      if (done) begin
        if (done_cnt == 0) done_rel = cyc - run_base - 1;
        done_cnt++;
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int exp_beat_data(input int i);
    return (i < 9) ? exp_c[i] : 234;
  endfunction

  function automatic bit exp_beat_rl(input int i);
    return (i < 9) && (i % 3 == 2);
  endfunction

  function automatic bit exp_beat_last(input int i);
    return (i == N_BEATS - 1);
  endfunction

  function automatic int exp_beat_edge(input int i);
    return (i < 9) ? 3 + 3 * i : 28;
  endfunction

  task automatic clear_records();
    beat_data.delete();
    beat_rl.delete();
    beat_last.delete();
    beat_edge.delete();
    addr_q.delete();
    done_cnt        = 0;
    done_rel        = -1;
    first_valid_rel = -1;
    stab_err        = 0;
    stall_cnt       = 0;
  endtask

  // Pulses start, optionally re-pulses it at beats 2 and 7, and waits
  // (bounded) for the done pulse plus a few idle cycles.
  task automatic apply_stimulus(input bit toggle, input bit extra_starts);
    bit pulsed2 = 1'b0;
    bit pulsed7 = 1'b0;
    clear_records();
    toggle_ready = toggle;
    @(posedge clk);
    #1;
    start    = 1'b1;
    run_base = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 400 && done_cnt == 0; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (extra_starts && !pulsed2 && beat_data.size() >= 2) begin
        start = 1'b1;
        pulsed2 = 1'b1;
      end else if (extra_starts && !pulsed7 && beat_data.size() >= 7) begin
        start = 1'b1;
        pulsed7 = 1'b1;
      end
    end
    start = 1'b0;
    check_output("run_completed", 64'(done_cnt > 0), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    toggle_ready = 1'b0;
  endtask

  task automatic check_sequence(input string run);
    check_output({run, "_beat_count"}, 64'(beat_data.size()), 64'(N_BEATS));
    for (int i = 0; i < beat_data.size() && i < N_BEATS; i++) begin
      check_output($sformatf("%s_data%0d", run, i), 64'(beat_data[i]),
                   64'(exp_beat_data(i)));
      check_output($sformatf("%s_row_last%0d", run, i), 64'(beat_rl[i]),
                   64'(exp_beat_rl(i)));
      check_output($sformatf("%s_last%0d", run, i), 64'(beat_last[i]),
                   64'(exp_beat_last(i)));
    end
    check_output({run, "_done_count"}, 64'(done_cnt), 64'd1);
    check_output({run, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check_output({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check_output({tag, "_m_valid"}, 64'(m_if.m_valid), 64'd0);
    check_output({tag, "_m_data"}, 64'(m_if.m_data), 64'd0);
    check_output({tag, "_m_row_last"}, 64'(m_if.m_row_last), 64'd0);
    check_output({tag, "_m_last"}, 64'(m_if.m_last), 64'd0);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) mem[i] = (i < 9) ? DATA_W'(exp_c[i]) : '0;
    reset = 1'b1;
    start = 1'b0;
    clear_records();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Run 1: ready tied high, full timing and read-address checks
    $display("[TB] run 1: m_ready high");
    apply_stimulus(1'b0, 1'b0);
    check_sequence("run1");
    for (int i = 0; i < beat_edge.size() && i < N_BEATS; i++)
      check_output($sformatf("run1_edge%0d", i), 64'(beat_edge[i]), 64'(exp_beat_edge(i)));
    check_output("run1_first_valid", 64'(first_valid_rel), 64'd2);
    check_output("run1_done_edge", 64'(done_rel), 64'(DONE_REL));
    check_output("run1_rd_count", 64'(addr_q.size()), 64'd9);
    for (int i = 0; i < addr_q.size() && i < 9; i++)
      check_output($sformatf("run1_rd_addr%0d", i), 64'(addr_q[i]), 64'(i));

    // Run 2: ready toggling every cycle
    $display("[TB] run 2: m_ready toggling");
    apply_stimulus(1'b1, 1'b0);
    check_sequence("run2");
    check_output("run2_stalls_seen", 64'(stall_cnt > 0), 64'd1);
    check_output("run2_stable_while_stalled", 64'(stab_err), 64'd0);

    // Run 3: reset while beat 4 (value 15) is on the stream
    $display("[TB] run 3: reset mid-run");
    clear_records();
    @(posedge clk);
    #1;
    start    = 1'b1;
    run_base = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (m_if.m_valid && m_if.m_data == 15) found = 1'b1;
    end
    check_output("run3_beat4_seen", 64'(found), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("run3_no_done", 64'(done_cnt), 64'd0);
    apply_stimulus(1'b0, 1'b0);
    check_sequence("run3_restart");

    // Run 4: start re-pulsed while busy is ignored
    $display("[TB] run 4: start while busy");
    apply_stimulus(1'b0, 1'b1);
    check_sequence("run4");
    repeat (10) @(posedge clk);
    #1;
    check_output("run4_no_restart_done", 64'(done_cnt), 64'd1);
    check_output("run4_no_restart_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
- Read-out end of the 3x3 matrix MAC datapath.
- After the MAC raises done, this block reads the result matrix C (N*N words, row-major, index i*N+j) through a synchronous-read memory port.
- It streams each word out on a valid/ready master interface to the downstream consumer (host bridge / UART packer), marking row and matrix boundaries.

Parameters:
- N, 3: matrix dimension; N*N elements streamed per run.
- DATA_W, 32: width of C elements and of stream data.
- ADDR_W, 4: read address width; requires 2^ADDR_W >= N*N.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a read-out run; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final beat's handshake.
- rd_en  out  1  memory read strobe.
- rd_addr  out  ADDR_W  memory read address.
- rd_data  in  DATA_W  memory read data; valid the cycle after rd_en=1.
- m_valid  out  1  stream word valid.
- m_ready  in  1  consumer accepts the word.
- m_data  out  DATA_W  stream word.
- m_row_last  out  1  high on a data beat with column j = N-1.
- m_last  out  1  high on the final beat of the run.

Behaviour:
- Reset (asynchronous, immediate, also mid-run):
  - state=IDLE; idx, row and col counters = 0.
  - busy=0, done=0, rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_row_last=0, m_last=0, sum=0.
  - An in-flight beat is dropped. No partial completion: done is not pulsed.
- FSM states: IDLE, ISSUE, CAPTURE, SEND, CSUM (only with the feature), DONE_STATE.
- IDLE:
  - done<=0.
  - On start=1: idx/row/col<=0, sum<=0, go to ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - rd_en=1, rd_addr=idx for exactly this cycle.
  - Go to CAPTURE.
- CAPTURE:
  - m_data<=rd_data, m_valid<=1.
  - m_row_last<=(col==N-1).
  - m_last<=(idx==N*N-1) when the feature is off; 0 when it is on.
  - Go to SEND.
- SEND:
  - Hold m_data, m_valid and the flags stable until m_valid & m_ready at a clock edge.
  - On handshake: sum<=sum+m_data.
  - If idx<N*N-1: idx++; col++ with wrap to 0 and row++ at col==N-1; m_valid<=0; go to ISSUE.
  - Else: go to DONE_STATE (feature off) or CSUM (feature on).
- DONE_STATE:
  - m_valid<=0, done<=1, go to IDLE.
  - done is therefore high for exactly one cycle.
- Timing with m_ready tied high:
  - start sampled at edge E0; m_valid high after E2.
  - Beat k handshakes at edge E(3+3k).
  - One beat per 3 cycles maximum; no combinational path from m_ready to any output.
- Backpressure: m_ready low stalls indefinitely in SEND with all stream outputs unchanged.
- Arithmetic:
  - idx compares against the constant N*N-1.
  - rd_addr = idx truncated to ADDR_W.
  - sum is DATA_W bits and wraps modulo 2^DATA_W.

Optional Feature:
- Macro: MATRIX_STREAM_CHECKSUM_EN.
- Defined:
  - At the last data handshake, m_data<=sum+m_data (the modulo-2^DATA_W sum of all N*N elements).
  - In the same update: m_valid stays 1, m_last<=1, m_row_last<=0; go to CSUM.
  - CSUM holds the word until handshake, then goes to DONE_STATE.
  - A run is N*N+1 beats; m_last is never set on a data beat.
- Undefined:
  - CSUM state and the sum register are absent.
  - A run is N*N beats, with m_last on the last data beat.

Test Plan:
- Memory model holds C = {14,6,12,47,15,30,73,17,20}; start pulsed, m_ready=1 -> m_data sequence 14,6,12,47,15,30,73,17,20; m_row_last on 12, 30 and 20; m_last only on 20; first m_valid after E2; last handshake at E27; done high one cycle after E28.
- Same data, m_ready toggled 0/1 each cycle -> identical data and flag sequence; m_data stable while m_valid=1 and m_ready=0; no beat lost or duplicated.
- Assert reset during beat 4 (value 15) -> all outputs 0 immediately; no done pulse; new start then streams the full sequence from 14.
- Pulse start again while busy, at beats 2 and 7 -> ignored; exactly 9 beats and one done pulse.
- Each ISSUE cycle -> rd_en high exactly one cycle per element, rd_addr = 0..8 in order.
- With MATRIX_STREAM_CHECKSUM_EN -> 10 beats; beat 10 m_data=234 with m_last=1, m_row_last=0; all data beats m_last=0.
